// File: rtl/gci_std_display_vram_write_buffer.sv
// ---------------------------------------------------------------------------
// gci_std_display_vram_write_buffer
//
// Buffers pixel write commands in a small FIFO. A four-state arbiter drains
// the FIFO into VRAM in bursts of at most P_BURST_MAX accesses per grant.
//
// Ports:
//   iCLOCK       system clock
//   inRESET      asynchronous reset, active-low
//   iRESET_SYNC  synchronous clear, active-high; drops everything in flight
//   iWR_REQ      write command strobe
//   iWR_ADDR     write word address
//   iWR_DATA     write pixel data
//   oWR_FULL     back-pressure; asserted one entry early
//   oEMPTY       FIFO holds no entries
//   oIF_REQ      VRAM arbitration request
//   iIF_ACK      arbitration grant pulse
//   oIF_FINISH   arbitration release pulse
//   oIF_ENA      VRAM access strobe; each strobe pops one entry
//   iIF_BUSY     VRAM stall
//   oIF_RW       access direction, 1 = write
//   oIF_ADDR     access address
//   oIF_DATA     access data, pixel zero-extended to 32 bits
// ---------------------------------------------------------------------------
module gci_std_display_vram_write_buffer #(
  parameter int P_MEM_ADDR_N = 19,
  parameter int P_DEPTH_N    = 4,
  parameter int P_BURST_MAX  = 8
) (
  input  logic                    iCLOCK,
  input  logic                    inRESET,
  input  logic                    iRESET_SYNC,
  input  logic                    iWR_REQ,
  input  logic [P_MEM_ADDR_N-1:0] iWR_ADDR,
  input  logic [15:0]             iWR_DATA,
  output logic                    oWR_FULL,
  output logic                    oEMPTY,
  output logic                    oIF_REQ,
  input  logic                    iIF_ACK,
  output logic                    oIF_FINISH,
  output logic                    oIF_ENA,
  input  logic                    iIF_BUSY,
  output logic                    oIF_RW,
  output logic [P_MEM_ADDR_N-1:0] oIF_ADDR,
  output logic [31:0]             oIF_DATA
);

  localparam int DEPTH   = 1 << P_DEPTH_N;
  localparam int CNT_W   = P_DEPTH_N + 1;
  localparam int BURST_W = $clog2(P_BURST_MAX + 1);

  localparam logic [CNT_W-1:0]     CNT_DEPTH   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]     CNT_ONE     = CNT_W'(1);
  localparam logic [P_DEPTH_N-1:0] PTR_ONE     = P_DEPTH_N'(1);
  localparam logic [BURST_W-1:0]   BURST_LIMIT = BURST_W'(P_BURST_MAX);
  localparam logic [BURST_W-1:0]   BURST_ONE   = BURST_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WRITE,
    ST_FINISH
  } state_t;

  logic [P_MEM_ADDR_N-1:0] fifo_addr_q [DEPTH];
  logic [15:0]             fifo_data_q [DEPTH];

  logic [P_DEPTH_N-1:0] wr_ptr_q, wr_ptr_d;
  logic [P_DEPTH_N-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  state_t               state_q, state_d;
  logic                 if_req_q, if_req_d;
  logic                 if_finish_q, if_finish_d;

  logic push;
  logic pop;

  // A push is refused only when every slot is occupied; a push coinciding
  // with the synchronous clear is dropped along with everything else.
  assign push = iWR_REQ && !iRESET_SYNC && (count_q != CNT_DEPTH);
  assign pop  = (state_q == ST_WRITE) && (count_q != '0) && !iIF_BUSY &&
                (burst_cnt_q < BURST_LIMIT);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    burst_cnt_d = burst_cnt_q;
    state_d     = state_q;
    if_req_d    = 1'b0;
    if_finish_d = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // oIF_REQ / oIF_FINISH are registered alongside the state so each is
    // high exactly while the FSM sits in REQ / FINISH.
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          state_d  = ST_REQ;
          if_req_d = 1'b1;
        end
      end
      ST_REQ: begin
        if (iIF_ACK) begin
          state_d     = ST_WRITE;
          burst_cnt_d = '0;
        end else begin
          if_req_d = 1'b1;
        end
      end
      ST_WRITE: begin
        if (pop) burst_cnt_d = burst_cnt_q + BURST_ONE;
        // Decide on the post-update view so the grant is released right
        // after the last access; a simultaneous push keeps the burst going.
        if ((count_d == '0) || (burst_cnt_d >= BURST_LIMIT)) begin
          state_d     = ST_FINISH;
          if_finish_d = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Synchronous clear abandons any burst silently: no FINISH pulse.
    if (iRESET_SYNC) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      burst_cnt_d = '0;
      state_d     = ST_IDLE;
      if_req_d    = 1'b0;
      if_finish_d = 1'b0;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      burst_cnt_q <= '0;
      state_q     <= ST_IDLE;
      if_req_q    <= 1'b0;
      if_finish_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      burst_cnt_q <= burst_cnt_d;
      state_q     <= state_d;
      if_req_q    <= if_req_d;
      if_finish_q <= if_finish_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge iCLOCK) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= iWR_ADDR;
      fifo_data_q[wr_ptr_q] <= iWR_DATA;
    end
  end

  assign oWR_FULL   = (count_q >= (CNT_DEPTH - CNT_ONE));
  assign oEMPTY     = (count_q == '0);
  assign oIF_REQ    = if_req_q;
  assign oIF_FINISH = if_finish_q;
  assign oIF_ENA    = pop;
  // Access bus is zero whenever no access is being strobed.
  assign oIF_RW     = pop;
  assign oIF_ADDR   = pop ? fifo_addr_q[rd_ptr_q] : '0;
  assign oIF_DATA   = pop ? {16'h0000, fifo_data_q[rd_ptr_q]} : '0;

endmodule
